// File: rtl/zx_pixel_plotter_if.sv
// Command and screen-RAM port bundle for zx_pixel_plotter.
// The plotter engine takes the slave modport; the requester and RAM side take master.
interface zx_pixel_plotter_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_x;
   logic [7:0]  cmd_y;
   logic [7:0]  cmd_data;
   logic [12:0] mem_addr;
   logic        mem_re;
   logic [7:0]  mem_rdata;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        busy;
   logic        err;

   modport master (
      output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data, mem_rdata,
      input  cmd_ready, mem_addr, mem_re, mem_wdata, mem_we, busy, err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data, mem_rdata,
      output cmd_ready, mem_addr, mem_re, mem_wdata, mem_we, busy, err
   );
endinterface

// File: rtl/zx_pixel_plotter.sv
// Read-modify-write pixel engine for the ZX Spectrum 256x192 bitmap, plus linear screen fill.
// Define PLOTTER_RESET_CLEAR_EN to fill the screen with CLEAR_BYTE after every reset release.
module zx_pixel_plotter #(
   parameter logic [7:0] CLEAR_BYTE = 8'h00
) (
   input  logic              clk,
   input  logic              reset,
   zx_pixel_plotter_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_MODIFY,
      ST_WRITE,
      ST_FILL
   } state_t;

   localparam logic [1:0]  OP_SET    = 2'b00;
   localparam logic [1:0]  OP_CLEAR  = 2'b01;
   localparam logic [1:0]  OP_TOGGLE = 2'b10;
   localparam logic [1:0]  OP_FILL   = 2'b11;
   localparam logic [12:0] FILL_LAST = 13'd6143;

   state_t      state_reg, state_next;
   logic [12:0] addr_reg, addr_next;
   logic [1:0]  op_reg, op_next;
   logic [7:0]  mask_reg, mask_next;
   logic [7:0]  fill_byte_reg, fill_byte_next;
   logic [12:0] fill_cnt_reg, fill_cnt_next;

   logic        cmd_ready_reg, cmd_ready_next;
   logic        busy_reg, busy_next;
   logic        err_reg, err_next;
   logic        mem_re_reg, mem_re_next;
   logic        mem_we_reg, mem_we_next;
   logic [12:0] mem_addr_reg, mem_addr_next;
   logic [7:0]  mem_wdata_reg, mem_wdata_next;

   logic        accept;
   logic        fill_cmd;
   logic        row_ok;
   logic        start_init;
   logic [12:0] cmd_addr;
   logic [7:0]  cmd_mask;
   logic [7:0]  modified;

`ifdef PLOTTER_RESET_CLEAR_EN
   logic init_pending_reg, init_pending_next;
   assign start_init = init_pending_reg;
`else
   assign start_init = 1'b0;
`endif

   assign accept   = cmd_ready_reg & bus.cmd_valid;
   assign fill_cmd = (bus.cmd_op == OP_FILL);
   assign row_ok   = (bus.cmd_y[7:6] != 2'b11);

   // Spectrum screen layout: third, pixel line in cell, character row, column byte.
   assign cmd_addr = {bus.cmd_y[7:6], bus.cmd_y[2:0], bus.cmd_y[5:3], bus.cmd_x[7:3]};

   // MSB is the leftmost pixel of the byte.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_mask
         assign cmd_mask[gi] = (bus.cmd_x[2:0] == 3'(7 - gi));
      end
   endgenerate

   always_comb begin
      case (op_reg)
         OP_SET:    modified = bus.mem_rdata | mask_reg;
         OP_CLEAR:  modified = bus.mem_rdata & ~mask_reg;
         OP_TOGGLE: modified = bus.mem_rdata ^ mask_reg;
         default:   modified = bus.mem_rdata;
      endcase
   end

   // State register together with the datapath latches and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         addr_reg      <= '0;
         op_reg        <= '0;
         mask_reg      <= '0;
         fill_byte_reg <= '0;
         fill_cnt_reg  <= '0;
         cmd_ready_reg <= 1'b0;
         busy_reg      <= 1'b0;
         err_reg       <= 1'b0;
         mem_re_reg    <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
`ifdef PLOTTER_RESET_CLEAR_EN
         init_pending_reg <= 1'b1;
`endif
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         op_reg        <= op_next;
         mask_reg      <= mask_next;
         fill_byte_reg <= fill_byte_next;
         fill_cnt_reg  <= fill_cnt_next;
         cmd_ready_reg <= cmd_ready_next;
         busy_reg      <= busy_next;
         err_reg       <= err_next;
         mem_re_reg    <= mem_re_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
`ifdef PLOTTER_RESET_CLEAR_EN
         init_pending_reg <= init_pending_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start_init) begin
               state_next = ST_FILL;
            end else if (accept) begin
               if (fill_cmd)
                  state_next = ST_FILL;
               else if (row_ok)
                  state_next = ST_READ;
            end
         end
         ST_READ:   state_next = ST_MODIFY;
         ST_MODIFY: state_next = ST_WRITE;
         ST_WRITE:  state_next = ST_IDLE;
         ST_FILL: begin
            if (fill_cnt_reg == FILL_LAST)
               state_next = ST_IDLE;
         end
         default:   state_next = ST_IDLE;
      endcase
   end

   // Outputs are computed for the state being entered so they can be registered.
   always_comb begin
      addr_next      = addr_reg;
      op_next        = op_reg;
      mask_next      = mask_reg;
      fill_byte_next = fill_byte_reg;
      fill_cnt_next  = fill_cnt_reg;
      cmd_ready_next = 1'b0;
      busy_next      = 1'b1;
      err_next       = 1'b0;
      mem_re_next    = 1'b0;
      mem_we_next    = 1'b0;
      mem_addr_next  = '0;
      mem_wdata_next = '0;
`ifdef PLOTTER_RESET_CLEAR_EN
      init_pending_next = init_pending_reg;
      if (start_init)
         init_pending_next = 1'b0;
`endif

      if (state_reg == ST_IDLE) begin
         if (state_next == ST_READ) begin
            addr_next = cmd_addr;
            op_next   = bus.cmd_op;
            mask_next = cmd_mask;
         end else if (state_next == ST_FILL) begin
            fill_cnt_next  = '0;
            fill_byte_next = start_init ? CLEAR_BYTE : bus.cmd_data;
         end else begin
            err_next = accept & ~fill_cmd & ~row_ok;
         end
      end else if (state_reg == ST_FILL && state_next == ST_FILL) begin
         fill_cnt_next = fill_cnt_reg + 13'd1;
      end

      case (state_next)
         ST_IDLE: begin
            cmd_ready_next = 1'b1;
            busy_next      = 1'b0;
         end
         ST_READ: begin
            mem_re_next   = 1'b1;
            mem_addr_next = addr_next;
         end
         ST_MODIFY: begin
            mem_addr_next = addr_reg;
         end
         ST_WRITE: begin
            mem_we_next    = 1'b1;
            mem_addr_next  = addr_reg;
            mem_wdata_next = modified;
         end
         ST_FILL: begin
            mem_we_next    = 1'b1;
            mem_addr_next  = fill_cnt_next;
            mem_wdata_next = fill_byte_next;
         end
         default: begin
            busy_next = 1'b1;
         end
      endcase
   end

   assign bus.cmd_ready = cmd_ready_reg;
   assign bus.busy      = busy_reg;
   assign bus.err       = err_reg;
   assign bus.mem_re    = mem_re_reg;
   assign bus.mem_we    = mem_we_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_zx_pixel_plotter.sv
// Self-checking bench for zx_pixel_plotter: vector table, corner sequences, random ops vs a screen model.
// Build with PLOTTER_RESET_CLEAR_EN defined to also exercise the reset-time clear fill.
module tb_zx_pixel_plotter;

   localparam logic [7:0] CLEAR_BYTE = 8'h00;

   logic clk = 1'b0;
   logic reset;

   zx_pixel_plotter_if bus ();

   zx_pixel_plotter #(.CLEAR_BYTE(CLEAR_BYTE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Screen RAM model: synchronous read with one cycle of latency, plus a backdoor poke port.
   logic [7:0]  ram [0:8191];
   logic [7:0]  ref_ram [0:6143];
   logic        poke_en = 1'b0;
   logic [12:0] poke_addr = '0;
   logic [7:0]  poke_data = '0;

   always @(posedge clk) begin
      if (poke_en)
         ram[poke_addr] <= poke_data;
      else if (bus.mem_we)
         ram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re)
         bus.mem_rdata <= ram[bus.mem_addr];
   end

   logic [20:0] wr_q [$];
   int          overlap = 0;

   always @(negedge clk) begin
      if (bus.mem_we)
         wr_q.push_back({bus.mem_addr, bus.mem_wdata});
      if (bus.mem_re && bus.mem_we)
         overlap++;
   end

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [7:0]  data;
      logic [7:0]  pre;
      logic [12:0] addr;
      logic [7:0]  wdata;
      logic        err;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string name, input int budget);
      int n = 0;
      while (bus.cmd_ready !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (bus.cmd_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s: cmd_ready timeout, got 0, expected 1", name);
      end
   endtask

   task automatic poke(input logic [12:0] a, input logic [7:0] d);
      poke_en   = 1'b1;
      poke_addr = a;
      poke_data = d;
      @(negedge clk);
      poke_en   = 1'b0;
   endtask

   // Reference screen geometry: thirds of 64 lines, 8 pixel lines per cell, 32 bytes per row.
   function automatic logic [12:0] ref_addr(input int x, input int y);
      return 13'((y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + x / 8);
   endfunction

   function automatic logic [7:0] ref_apply(input logic [1:0] op, input logic [7:0] old, input int x);
      logic [7:0] bitm;
      bitm = 8'(1 << (7 - x % 8));
      case (op)
         2'd0:    return old | bitm;
         2'd1:    return old & ~bitm;
         default: return old ^ bitm;
      endcase
   endfunction

   // Called at a negedge; leaves the bench at the negedge where cmd_ready is expected back.
   task automatic pixel_txn(input string name, input logic [1:0] op, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] d, input logic [12:0] exp_addr,
                            input logic [7:0] exp_wdata, input logic exp_err);
      wait_ready({name, ".ready"}, 20);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_x     = x;
      bus.cmd_y     = y;
      bus.cmd_data  = d;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (exp_err) begin
         check({name, ".err"}, {31'd0, bus.err}, 32'd1);
         check({name, ".strobes"}, {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
         check({name, ".ready_kept"}, {31'd0, bus.cmd_ready}, 32'd1);
         @(negedge clk);
         check({name, ".err_end"}, {31'd0, bus.err}, 32'd0);
      end else begin
         check({name, ".read"}, {17'd0, bus.mem_re, bus.mem_we, bus.cmd_ready, bus.mem_addr},
               {17'd0, 1'b1, 1'b0, 1'b0, exp_addr});
         @(negedge clk);
         check({name, ".modify"}, {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
         @(negedge clk);
         check({name, ".write"}, {2'd0, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata, 8'd0},
               {2'd0, 1'b0, 1'b1, exp_addr, exp_wdata, 8'd0});
         @(negedge clk);
         check({name, ".done"}, {29'd0, bus.cmd_ready, bus.busy, bus.mem_we}, {29'd0, 3'b100});
      end
      $display("txn %s op=%0d x=%0d y=%0d addr=0x%03h wdata=0x%02h err=%0d",
               name, op, x, y, exp_addr, exp_wdata, exp_err);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int accepts;
      int bad;
      int busy_cnt;
      int found;

      reset         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'd0;
      bus.cmd_x     = 8'd0;
      bus.cmd_y     = 8'd0;
      bus.cmd_data  = 8'd0;

      vecs[0] = '{2'd0, 8'd0,   8'd0,   8'h11, 8'h00, 13'h000, 8'h80, 1'b0};
      vecs[1] = '{2'd0, 8'd255, 8'd191, 8'h22, 8'hF0, 13'h17FF, 8'hF1, 1'b0};
      vecs[2] = '{2'd1, 8'd9,   8'd1,   8'h33, 8'hFF, 13'h101, 8'hBF, 1'b0};
      vecs[3] = '{2'd2, 8'd100, 8'd50,  8'h44, 8'h5A, 13'h2CC, 8'h52, 1'b0};
      vecs[4] = '{2'd0, 8'd7,   8'd64,  8'h55, 8'h00, 13'h800, 8'h01, 1'b0};
      vecs[5] = '{2'd1, 8'd128, 8'd100, 8'h66, 8'h81, 13'hC90, 8'h01, 1'b0};
      vecs[6] = '{2'd0, 8'd0,   8'd0,   8'h77, 8'hFF, 13'h000, 8'hFF, 1'b0};
      vecs[7] = '{2'd0, 8'd3,   8'd192, 8'h00, 8'h00, 13'h000, 8'h00, 1'b1};
      vecs[8] = '{2'd1, 8'd0,   8'd255, 8'h00, 8'h00, 13'h000, 8'h00, 1'b1};
      vecs[9] = '{2'd2, 8'd17,  8'd200, 8'h00, 8'h00, 13'h000, 8'h00, 1'b1};

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset.outputs",
            {8'd0, bus.cmd_ready, bus.busy, bus.err, bus.mem_re, bus.mem_we, bus.mem_addr, 8'd0},
            32'd0);
      check("reset.wdata", {24'd0, bus.mem_wdata}, 32'd0);

      base = wr_q.size();
      reset = 1'b1;
      @(negedge clk);
`ifdef PLOTTER_RESET_CLEAR_EN
      check("init.busy", {30'd0, bus.cmd_ready, bus.busy}, 32'd1);
      wait_ready("init", 7000);
      check("init.count", wr_q.size() - base, 32'd6144);
      bad = 0;
      for (int i = 0; i < 6144 && base + i < wr_q.size(); i++)
         if (wr_q[base + i] !== {13'(i), CLEAR_BYTE}) bad++;
      check("init.data", bad, 32'd0);
      $display("txn init_fill writes=%0d", wr_q.size() - base);
`else
      check("release.ready", {30'd0, bus.cmd_ready, bus.busy}, 32'd2);
      check("release.no_writes", wr_q.size() - base, 32'd0);
`endif

      // Vector table.
      for (int i = 0; i < 10; i++) begin
         if (!vecs[i].err)
            poke(vecs[i].addr, vecs[i].pre);
         pixel_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].data,
                   vecs[i].addr, vecs[i].wdata, vecs[i].err);
      end

      // Toggle (9,1) twice with cmd_valid held through the first operation.
      poke(13'h101, 8'h00);
      base = wr_q.size();
      accepts = 0;
      wait_ready("hold.ready", 20);
      bus.cmd_op    = 2'd2;
      bus.cmd_x     = 8'd9;
      bus.cmd_y     = 8'd1;
      bus.cmd_valid = 1'b1;
      for (int c = 0; c < 20 && accepts < 2; c++) begin
         if (bus.cmd_ready) accepts++;
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("hold.accepts", accepts, 32'd2);
      check("hold.writes", wr_q.size() - base, 32'd2);
      if (wr_q.size() - base >= 2) begin
         check("hold.first", {11'd0, wr_q[base]}, {11'd0, 13'h101, 8'h40});
         check("hold.second", {11'd0, wr_q[base + 1]}, {11'd0, 13'h101, 8'h00});
      end
      $display("txn hold_toggle accepts=%0d writes=%0d", accepts, wr_q.size() - base);

      // Full fill with 0xAA.
      wait_ready("fill.ready", 20);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd3;
      bus.cmd_x     = 8'($urandom);
      bus.cmd_y     = 8'($urandom);
      bus.cmd_data  = 8'hAA;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bad = 0;
      busy_cnt = 0;
      for (int i = 0; i < 6144; i++) begin
         if (bus.busy) busy_cnt++;
         if (!(bus.mem_we && !bus.mem_re && bus.mem_addr == 13'(i) && bus.mem_wdata == 8'hAA))
            bad++;
         @(negedge clk);
      end
      check("fill.sequence", bad, 32'd0);
      check("fill.busy_cycles", busy_cnt, 32'd6144);
      check("fill.done", {29'd0, bus.cmd_ready, bus.busy, bus.mem_we}, {29'd0, 3'b100});
      $display("txn fill data=0xAA bad=%0d busy=%0d", bad, busy_cnt);

      // Fill with 0x55, aborted by reset at write 100.
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd3;
      bus.cmd_data  = 8'h55;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      found = 0;
      for (int c = 0; c < 300 && found == 0; c++) begin
         if (bus.mem_we && bus.mem_addr == 13'd100) found = 1;
         else @(negedge clk);
      end
      check("abort.reached", found, 32'd1);
      reset = 1'b0;
      #1;
      check("abort.drop", {29'd0, bus.mem_we, bus.cmd_ready, bus.busy}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort.partial", {16'd0, ram[99], ram[100]}, {16'd0, 8'h55, 8'hAA});
`ifdef PLOTTER_RESET_CLEAR_EN
      check("abort.init_busy", {31'd0, bus.busy}, 32'd1);
      wait_ready("abort.init", 7000);
      for (int i = 0; i < 6144; i++) ref_ram[i] = CLEAR_BYTE;
`else
      check("abort.ready", {31'd0, bus.cmd_ready}, 32'd1);
      for (int i = 0; i < 6144; i++) ref_ram[i] = (i < 100) ? 8'h55 : 8'hAA;
`endif
      $display("txn fill_abort at write 100");

      // Random pixel commands against the screen model.
      for (int i = 0; i < 60; i++) begin
         logic [1:0]  op;
         logic [7:0]  x;
         logic [7:0]  y;
         logic [12:0] a;
         logic [7:0]  w;
         logic        e;
         op = 2'($urandom_range(0, 2));
         x  = 8'($urandom_range(0, 255));
         if (i % 7 == 3)
            y = 8'($urandom_range(192, 255));
         else if ($urandom_range(0, 1) == 1)
            y = 8'($urandom_range(0, 15));
         else
            y = 8'($urandom_range(0, 191));
         e = (y >= 8'd192);
         a = '0;
         w = '0;
         if (!e) begin
            a = ref_addr(x, y);
            w = ref_apply(op, ref_ram[a], x);
            ref_ram[a] = w;
         end
         pixel_txn($sformatf("rnd%0d", i), op, x, y, 8'($urandom), a, w, e);
      end

      repeat (2) @(negedge clk);
      bad = 0;
      for (int i = 0; i < 6144; i++)
         if (ram[i] !== ref_ram[i]) bad++;
      check("final.ram_image", bad, 32'd0);
      check("final.strobe_overlap", overlap, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
